// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one multi-cycle main memory between the I-cache and
// D-cache miss handlers. It serializes 8-word block fills and single-word
// D-cache write-throughs, issues pipelined read addresses, and steers each
// returning word to its requester along with the word index.
//
// Ports
//   clk, rst_n                  clock, asynchronous active-low reset
//   i_req, i_addr               I-cache fill request and miss address
//   d_req, d_wr, d_addr, d_wdata D-cache request (fill or single-word write)
//   fill_data, fill_idx         returned word and its index in the block
//   i_fill_valid, d_fill_valid  fill_data belongs to I / D this cycle
//   i_done, d_done              one-cycle completion pulses
//   mem_addr, mem_wdata         memory address and write data
//   mem_enable, mem_wr          memory access strobe and write select
//   mem_data_out, mem_data_valid memory read-return data and valid
module mem_arbiter #(
    parameter int unsigned MEM_LAT = 4,
    parameter int unsigned WORDS   = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_req,
    input  logic [15:0] i_addr,
    input  logic        d_req,
    input  logic        d_wr,
    input  logic [15:0] d_addr,
    input  logic [15:0] d_wdata,
    output logic [15:0] fill_data,
    output logic [2:0]  fill_idx,
    output logic        i_fill_valid,
    output logic        d_fill_valid,
    output logic        i_done,
    output logic        d_done,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    output logic        mem_enable,
    output logic        mem_wr,
    input  logic [15:0] mem_data_out,
    input  logic        mem_data_valid
);

    localparam int unsigned IDX_W  = $clog2(WORDS);
    localparam int unsigned CNT_W  = $clog2(WORDS + 1);
    localparam int unsigned OFF_W  = IDX_W + 1;
    localparam int unsigned BASE_W = 16 - OFF_W;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FILL_I = 2'd1,
        FILL_D = 2'd2,
        WRITE  = 2'd3
    } state_t;

    // last_q: requester granted most recently (0 = I, 1 = D)
    localparam logic LAST_I = 1'b0;
    localparam logic LAST_D = 1'b1;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   ic_q, ic_d;
    logic [CNT_W-1:0]   rc_q, rc_d;
    logic               last_q, last_d;
    logic [BASE_W-1:0]  base_q, base_d;
    logic               pick_d;

    // Byte-offset bits of the I-cache address never reach memory.
    logic unused_i_addr_bits;
    assign unused_i_addr_bits = ^i_addr[OFF_W-1:0];

    // State, counters, fairness flag and latched block base.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ic_q    <= '0;
            rc_q    <= '0;
            last_q  <= LAST_I;
            base_q  <= '0;
        end else begin
            state_q <= state_d;
            ic_q    <= ic_d;
            rc_q    <= rc_d;
            last_q  <= last_d;
            base_q  <= base_d;
        end
    end

    // Next-state logic and output decode.
    always_comb begin
        state_d      = state_q;
        ic_d         = ic_q;
        rc_d         = rc_q;
        last_d       = last_q;
        base_d       = base_q;
        pick_d       = 1'b0;
        fill_data    = mem_data_out;
        fill_idx     = '0;
        i_fill_valid = 1'b0;
        d_fill_valid = 1'b0;
        i_done       = 1'b0;
        d_done       = 1'b0;
        mem_addr     = '0;
        mem_wdata    = '0;
        mem_enable   = 1'b0;
        mem_wr       = 1'b0;

        unique case (state_q)
            IDLE: begin
                // On conflict, grant whoever was not served last.
                if (i_req && d_req) begin
                    pick_d = (last_q == LAST_I);
                end else begin
                    pick_d = d_req;
                end
                if (i_req || d_req) begin
                    if (pick_d) begin
                        last_d  = LAST_D;
                        base_d  = d_addr[15:OFF_W];
                        state_d = d_wr ? WRITE : FILL_D;
                    end else begin
                        last_d  = LAST_I;
                        base_d  = i_addr[15:OFF_W];
                        state_d = FILL_I;
                    end
                end
            end

            FILL_I, FILL_D: begin
                // Reads are issued back to back; returns are counted separately.
                if (ic_q < CNT_W'(WORDS)) begin
                    mem_enable = 1'b1;
                    mem_addr   = {base_q, ic_q[IDX_W-1:0], 1'b0};
                    ic_d       = ic_q + CNT_W'(1);
                end
                fill_idx = 3'(rc_q);
                if (mem_data_valid) begin
                    if (state_q == FILL_I) begin
                        i_fill_valid = 1'b1;
                    end else begin
                        d_fill_valid = 1'b1;
                    end
                    rc_d = rc_q + CNT_W'(1);
                    if (rc_q == CNT_W'(WORDS - 1)) begin
                        if (state_q == FILL_I) begin
                            i_done = 1'b1;
                        end else begin
                            d_done = 1'b1;
                        end
                        ic_d    = '0;
                        rc_d    = '0;
                        state_d = IDLE;
                    end
                end
            end

            WRITE: begin
                mem_enable = 1'b1;
                mem_wr     = 1'b1;
                mem_addr   = d_addr;
                mem_wdata  = d_wdata;
                d_done     = 1'b1;
                state_d    = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Memory contract: every word returned during a fill answers a read
    // presented exactly MEM_LAT cycles earlier.
    a_mem_latency : assert property (@(posedge clk) disable iff (!rst_n)
        (((state_q == FILL_I) || (state_q == FILL_D)) && mem_data_valid)
            |-> $past(mem_enable && !mem_wr, MEM_LAT));

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares one multi-cycle main memory between the instruction-cache and data-cache miss handlers. It serializes 8-word cache-block fills and single-word data write-throughs, issues pipelined read addresses, and steers returning data to the requesting cache with a word index. Sits between both cache controllers and the single main memory instance; replaces the per-cache private memories.

## Interface
Parameters:
- MEM_LAT, 4: cycles from a read being presented to `mem_data_valid` for that word.
- WORDS, 8: 16-bit words per cache block; block = 16 bytes.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- i_req  in  1  I-cache fill request; held until `i_done`.
- i_addr  in  16  I-cache miss address; only [15:4] used; stable while `i_req`.
- d_req  in  1  D-cache request; held until `d_done`.
- d_wr  in  1  1 = single-word write, 0 = block fill; stable while `d_req`.
- d_addr  in  16  D-cache address; full word address for writes, [15:4] for fills.
- d_wdata  in  16  write data; stable while `d_req & d_wr`.
- fill_data  out  16  returned word; equals `mem_data_out`.
- fill_idx  out  3  index of the returned word within the block.
- i_fill_valid  out  1  `fill_data` belongs to the I-cache this cycle.
- d_fill_valid  out  1  `fill_data` belongs to the D-cache this cycle.
- i_done  out  1  one-cycle pulse; I transaction complete.
- d_done  out  1  one-cycle pulse; D transaction complete.
- mem_addr  out  16  memory address.
- mem_wdata  out  16  memory write data.
- mem_enable  out  1  memory access this cycle.
- mem_wr  out  1  memory write this cycle.
- mem_data_out  in  16  memory read data.
- mem_data_valid  in  1  `mem_data_out` valid.

## Operation
- States are IDLE, FILL_I, FILL_D and WRITE. Reset state is IDLE.
- Arbitration happens only in IDLE. A transaction is never preempted.
- IDLE, single request pending: go to FILL_I, FILL_D, or WRITE (`d_req & d_wr`).
- IDLE, both `i_req` and `d_req` pending: grant the requester not served last.
  - `last` register, reset value = I, so D wins the first conflict.
  - `last` updates on every grant.
- FILL_x:
  - Issue counter `ic` (0..WORDS) presents one read per cycle while `ic < WORDS`.
  - Read drive: `mem_enable=1`, `mem_wr=0`, `mem_addr={base[15:4], ic[2:0], 1'b0}`.
  - Receive counter `rc` increments on each `mem_data_valid`. `fill_idx=rc[2:0]`.
  - `x_fill_valid = mem_data_valid`.
  - On the cycle `rc==WORDS-1 & mem_data_valid`: assert `x_done` and go to IDLE. Counters clear.
- WRITE: exactly one cycle.
  - Drive `mem_enable=1`, `mem_wr=1`, `mem_addr=d_addr`, `mem_wdata=d_wdata`, `d_done=1`.
  - Next state IDLE.
- Requesters must drop `req` in the cycle after their `done`. A request still high in IDLE is a new transaction.
- `mem_data_valid` outside FILL states is ignored: no valid outputs, no counter change.
- `i_addr` and `d_addr` are latched into `base` at grant.
- Reset mid-transaction:
  - Immediate return to IDLE. `ic`, `rc` and `last` are reset.
  - All outputs 0: `mem_enable`, `mem_wr`, valids, dones, `fill_idx`, `mem_addr`, `mem_wdata`.
  - No `done` is issued for the aborted transaction.

## Timing
- Request high in IDLE cycle t → FILL begins at t+1.
  - Word k is presented at t+1+k.
  - Word k is valid at t+1+k+MEM_LAT.
  - `done` at t+WORDS+MEM_LAT (t+12 at defaults), coincident with the last word.
- Fill occupancy is WORDS+MEM_LAT cycles.
- Write: request at t → `d_done` and the memory write at t+1.
- Minimum gap between transactions is 1 IDLE cycle. The next grant is sampled in the IDLE cycle after `done`.
- Outputs in IDLE: `mem_enable=0`, valids 0, dones 0.

## Test plan
- I fill: `i_req`, `i_addr=0x1236` at t=0.
  - Reads 0x1230..0x123E at t=1..8.
  - `i_fill_valid` at t=5..12 with `fill_idx` 0..7.
  - `i_done` at t=12; `d_fill_valid` never asserted.
- Conflict: `i_req` and `d_req` (fill, `d_addr=0x4000`) both rise at t=0 after reset.
  - D served first.
  - I granted in the IDLE cycle after `d_done`.
  - Next simultaneous conflict grants I.
- Write during fill: `d_req`, `d_wr=1`, `d_addr=0x0102`, `d_wdata=0xBEEF` raised mid I-fill.
  - No memory write until after `i_done`.
  - Then one cycle with `mem_wr=1`, `mem_addr=0x0102`, `mem_wdata=0xBEEF`, `d_done=1`.
- Reset mid-fill: `rst_n` low after word 3 received.
  - All outputs 0 immediately; no `done`.
  - After release, a new `i_req` fills from `fill_idx` 0.
- Stray valid: `mem_data_valid` pulsed in IDLE → no valid/done outputs; the next fill still returns `fill_idx` 0..7.
- Back-to-back I fills:
  - `i_req` re-raised the cycle after `i_done` → second FILL_I starts 1 cycle later.
  - `i_req` held with no drop → a second fill occurs, per the new-transaction rule.
